alarm_clock_param: RTL and testbench

Parametrised alarm clock: a prescaled seconds/minutes/hours time-of-day counter with programmable modulus per field, synchronous time preset, a registered alarm time, and an alarm state machine with snooze, stop and auto-off. Successor to the fixed-width 2-bit clock/alarm block. It sits at the top of the clock datapath and drives display and buzzer logic.

---
 rtl/alarm_clock_param.sv | 197 +++++++++++++++++++
 tb/tb_alarm_clock_param.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_clock_param.sv
// Parametrised alarm clock: prescaled h:m:s counter with preset, registered alarm time,
// and an IDLE/RINGING/SNOOZED alarm machine with snooze, stop and auto-off.
module alarm_clock_param #(
  parameter int TICK_DIV   = 1,
  parameter int SEC_MOD    = 60,
  parameter int MIN_MOD    = 60,
  parameter int HOUR_MOD   = 24,
  parameter int SNOOZE_MIN = 5,
  parameter int RING_SECS  = 30,
  localparam int SW = $clog2(SEC_MOD),
  localparam int MW = $clog2(MIN_MOD),
  localparam int HW = $clog2(HOUR_MOD)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ena,
  input  logic          load,
  input  logic [HW-1:0] load_hours,
  input  logic [MW-1:0] load_minutes,
  input  logic [SW-1:0] load_seconds,
  input  logic          alarm_set,
  input  logic [HW-1:0] alarm_hours_in,
  input  logic [MW-1:0] alarm_minutes_in,
  input  logic          alarm_enable,
  input  logic          snooze,
  input  logic          stop,
  output logic [HW-1:0] hours,
  output logic [MW-1:0] minutes,
  output logic [SW-1:0] seconds,
  output logic          tick,
  output logic          alarm,
  output logic [1:0]    alarm_state
);

  localparam int PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SNZ_TOTAL = SNOOZE_MIN * SEC_MOD;
  localparam int RW        = $clog2(RING_SECS + 1);
  localparam int ZW        = $clog2(SNZ_TOTAL + 1);

  localparam logic [PW-1:0] P_LAST   = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] S_LAST   = SW'(SEC_MOD - 1);
  localparam logic [MW-1:0] M_LAST   = MW'(MIN_MOD - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(HOUR_MOD - 1);
  localparam logic [RW-1:0] RING_END = RW'(RING_SECS);
  localparam logic [ZW-1:0] SNZ_INIT = ZW'(SNZ_TOTAL);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZED = 2'd2
  } state_e;

  // Out-of-range preset/alarm fields collapse to zero
  function automatic logic [SW-1:0] fit_sec(input logic [SW-1:0] v);
    return (int'(v) >= SEC_MOD) ? '0 : v;
  endfunction

  function automatic logic [MW-1:0] fit_min(input logic [MW-1:0] v);
    return (int'(v) >= MIN_MOD) ? '0 : v;
  endfunction

  function automatic logic [HW-1:0] fit_hour(input logic [HW-1:0] v);
    return (int'(v) >= HOUR_MOD) ? '0 : v;
  endfunction

  logic [PW-1:0] presc_q, presc_d;
  logic [SW-1:0] sec_q, sec_d, inc_s;
  logic [MW-1:0] min_q, min_d, inc_m;
  logic [HW-1:0] hour_q, hour_d, inc_h;
  logic [HW-1:0] alm_h_q, alm_h_d;
  logic [MW-1:0] alm_m_q, alm_m_d;
  logic [RW-1:0] ring_q, ring_d, ring_inc;
  logic [ZW-1:0] snz_q, snz_d;
  state_e        state_q, state_d;
  logic          tick_q, tick_d;
  logic          alarm_q, alarm_d;
  logic          adv, s_wrap, m_wrap, trigger;

  always_comb begin
    adv      = ena && (presc_q == P_LAST) && !load;
    presc_d  = presc_q;
    if (load)
      presc_d = '0;
    else if (ena)
      presc_d = (presc_q == P_LAST) ? '0 : presc_q + PW'(1);

    s_wrap = (sec_q == S_LAST);
    m_wrap = (min_q == M_LAST);
    inc_s  = s_wrap ? '0 : sec_q + SW'(1);
    inc_m  = s_wrap ? (m_wrap ? '0 : min_q + MW'(1)) : min_q;
    inc_h  = (s_wrap && m_wrap) ? ((hour_q == H_LAST) ? '0 : hour_q + HW'(1)) : hour_q;

    sec_d  = sec_q;
    min_d  = min_q;
    hour_d = hour_q;
    if (load) begin
      sec_d  = fit_sec(load_seconds);
      min_d  = fit_min(load_minutes);
      hour_d = fit_hour(load_hours);
    end else if (adv) begin
      sec_d  = inc_s;
      min_d  = inc_m;
      hour_d = inc_h;
    end

    alm_h_d = alm_h_q;
    alm_m_d = alm_m_q;
    if (alarm_set) begin
      alm_h_d = fit_hour(alarm_hours_in);
      alm_m_d = fit_min(alarm_minutes_in);
    end

    // Match is against the alarm time held before this edge
    trigger = adv && alarm_enable && (inc_h == alm_h_q) && (inc_m == alm_m_q) && (inc_s == '0);

    ring_inc = ring_q + RW'(1);
    state_d  = state_q;
    ring_d   = ring_q;
    snz_d    = snz_q;
    if (!alarm_enable) begin
      state_d = ST_IDLE;
      ring_d  = '0;
      snz_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (trigger) begin
            state_d = ST_RINGING;
            ring_d  = '0;
          end
        end
        ST_RINGING: begin
          if (stop) begin
            state_d = ST_IDLE;
          end else if (snooze) begin
            state_d = ST_SNOOZED;
            snz_d   = SNZ_INIT;
          end else if (adv) begin
            ring_d = ring_inc;
            if (ring_inc == RING_END) state_d = ST_IDLE;
          end
        end
        ST_SNOOZED: begin
          if (stop) begin
            state_d = ST_IDLE;
          end else if (adv) begin
            snz_d = snz_q - ZW'(1);
            if (snz_q == ZW'(1)) begin
              state_d = ST_RINGING;
              ring_d  = '0;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    tick_d  = adv;
    alarm_d = (state_d == ST_RINGING);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      presc_q <= '0;
      sec_q   <= '0;
      min_q   <= '0;
      hour_q  <= '0;
      alm_h_q <= '0;
      alm_m_q <= '0;
      ring_q  <= '0;
      snz_q   <= '0;
      state_q <= ST_IDLE;
      tick_q  <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hour_q  <= hour_d;
      alm_h_q <= alm_h_d;
      alm_m_q <= alm_m_d;
      ring_q  <= ring_d;
      snz_q   <= snz_d;
      state_q <= state_d;
      tick_q  <= tick_d;
      alarm_q <= alarm_d;
    end
  end

  assign hours       = hour_q;
  assign minutes     = min_q;
  assign seconds     = sec_q;
  assign tick        = tick_q;
  assign alarm       = alarm_q;
  assign alarm_state = state_q;

endmodule

// File: tb/tb_alarm_clock_param.sv
// Directed bench for alarm_clock_param: three instances (prescaled, alarm, odd moduli)
// share stimulus; expected records are queued and checked by a separate monitor.
module tb_alarm_clock_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, ena, load, alarm_set, alarm_enable, snooze, stop;
  logic [1:0] ld_h, lc_h, al_h;
  logic [2:0] ld_m, lc_m, lc_s, al_m;
  logic [1:0] ld_s;

  logic [1:0] hours_a, hours_b, hours_c;
  logic [2:0] minutes_a, minutes_b, minutes_c;
  logic [1:0] seconds_a, seconds_b;
  logic [2:0] seconds_c;
  logic       tick_a, tick_b, tick_c, alarm_a, alarm_b, alarm_c;
  logic [1:0] state_a, state_b, state_c;

  alarm_clock_param #(.TICK_DIV(4), .SEC_MOD(4), .MIN_MOD(8), .HOUR_MOD(4),
                      .SNOOZE_MIN(1), .RING_SECS(3)) u_a (
    .clk(clk), .reset(reset), .ena(ena), .load(load),
    .load_hours(ld_h), .load_minutes(ld_m), .load_seconds(ld_s),
    .alarm_set(alarm_set), .alarm_hours_in(al_h), .alarm_minutes_in(al_m),
    .alarm_enable(alarm_enable), .snooze(snooze), .stop(stop),
    .hours(hours_a), .minutes(minutes_a), .seconds(seconds_a),
    .tick(tick_a), .alarm(alarm_a), .alarm_state(state_a));

  alarm_clock_param #(.TICK_DIV(1), .SEC_MOD(4), .MIN_MOD(8), .HOUR_MOD(4),
                      .SNOOZE_MIN(1), .RING_SECS(3)) u_b (
    .clk(clk), .reset(reset), .ena(ena), .load(load),
    .load_hours(ld_h), .load_minutes(ld_m), .load_seconds(ld_s),
    .alarm_set(alarm_set), .alarm_hours_in(al_h), .alarm_minutes_in(al_m),
    .alarm_enable(alarm_enable), .snooze(snooze), .stop(stop),
    .hours(hours_b), .minutes(minutes_b), .seconds(seconds_b),
    .tick(tick_b), .alarm(alarm_b), .alarm_state(state_b));

  alarm_clock_param #(.TICK_DIV(1), .SEC_MOD(5), .MIN_MOD(6), .HOUR_MOD(3),
                      .SNOOZE_MIN(1), .RING_SECS(3)) u_c (
    .clk(clk), .reset(reset), .ena(ena), .load(load),
    .load_hours(lc_h), .load_minutes(lc_m), .load_seconds(lc_s),
    .alarm_set(alarm_set), .alarm_hours_in(al_h), .alarm_minutes_in(al_m),
    .alarm_enable(alarm_enable), .snooze(snooze), .stop(stop),
    .hours(hours_c), .minutes(minutes_c), .seconds(seconds_c),
    .tick(tick_c), .alarm(alarm_c), .alarm_state(state_c));

  typedef struct {
    int    which;
    string name;
    int    h, m, s, tk, al, st;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_bad = 0;
  int   act_h, act_m, act_s, act_tk, act_al, act_st;
  bit   ok;

  task automatic push(input int which, input string name,
                      input int h, input int m, input int s,
                      input int tk, input int al, input int st);
    exp_t e;
    e.which = which; e.name = name;
    e.h = h; e.m = m; e.s = s; e.tk = tk; e.al = al; e.st = st;
    sb.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      mon_e = sb.pop_front();
      case (mon_e.which)
        0: begin
          act_h = int'(hours_a); act_m = int'(minutes_a); act_s = int'(seconds_a);
          act_tk = int'(tick_a); act_al = int'(alarm_a); act_st = int'(state_a);
        end
        1: begin
          act_h = int'(hours_b); act_m = int'(minutes_b); act_s = int'(seconds_b);
          act_tk = int'(tick_b); act_al = int'(alarm_b); act_st = int'(state_b);
        end
        default: begin
          act_h = int'(hours_c); act_m = int'(minutes_c); act_s = int'(seconds_c);
          act_tk = int'(tick_c); act_al = int'(alarm_c); act_st = int'(state_c);
        end
      endcase
      ok = (act_h == mon_e.h) && (act_m == mon_e.m) && (act_s == mon_e.s) &&
           (act_tk == mon_e.tk);
      if (mon_e.which == 1)
        ok = ok && (act_al == mon_e.al) && (act_st == mon_e.st);
      n_vec++;
      if (!ok) begin
        n_bad++;
        $display("FAIL %s: got %0d:%0d:%0d tick=%0d alarm=%0d state=%0d, want %0d:%0d:%0d tick=%0d alarm=%0d state=%0d",
                 mon_e.name, act_h, act_m, act_s, act_tk, act_al, act_st,
                 mon_e.h, mon_e.m, mon_e.s, mon_e.tk, mon_e.al, mon_e.st);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; ena = 1'b0; load = 1'b0; alarm_set = 1'b0;
    alarm_enable = 1'b0; snooze = 1'b0; stop = 1'b0;
    ld_h = '0; ld_m = '0; ld_s = '0; lc_h = '0; lc_m = '0; lc_s = '0;
    al_h = '0; al_m = '0;

    // Reset
    cyc();
    push(1, "reset", 0, 0, 0, 0, 0, 0);
    push(0, "reset_div", 0, 0, 0, 0, 0, 0);

    // Free run: prescaled instance advances every 4th edge
    reset = 1'b1; ena = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      cyc();
      push(0, "prescale", 0, k / 16, (k / 4) % 4, (k % 4 == 0) ? 1 : 0, 0, 0);
    end
    push(1, "free_run", 0, 4, 0, 1, 0, 0);

    // Presets, full wrap, out-of-range fields
    load = 1'b1; ld_h = 2'd3; ld_m = 3'd7; ld_s = 2'd3; lc_h = 2'd3; lc_m = 3'd7; lc_s = 3'd7;
    cyc();
    push(1, "load_max", 3, 7, 3, 0, 0, 0);
    push(2, "load_oor", 0, 0, 0, 0, 0, 0);
    push(0, "load_div", 3, 7, 3, 0, 0, 0);
    load = 1'b0;
    cyc();
    push(1, "full_wrap", 0, 0, 0, 1, 0, 0);
    push(2, "oor_adv", 0, 0, 1, 1, 0, 0);
    push(0, "presc_clr", 3, 7, 3, 0, 0, 0);
    load = 1'b1; ld_h = 2'd2; ld_m = 3'd6; ld_s = 2'd1; lc_h = 2'd2; lc_m = 3'd5; lc_s = 3'd4;
    cyc();
    push(1, "load2", 2, 6, 1, 0, 0, 0);
    push(2, "load_edge", 2, 5, 4, 0, 0, 0);
    load = 1'b0;
    cyc();
    push(1, "adv2", 2, 6, 2, 1, 0, 0);
    push(2, "wrap_c", 0, 0, 0, 1, 0, 0);

    // Arm alarm 1:2 and ring with auto-off
    ena = 1'b0; load = 1'b1; ld_h = 2'd1; ld_m = 3'd1; ld_s = 2'd3;
    alarm_set = 1'b1; al_h = 2'd1; al_m = 3'd2; alarm_enable = 1'b1;
    cyc(); push(1, "arm", 1, 1, 3, 0, 0, 0);
    load = 1'b0; alarm_set = 1'b0; ena = 1'b1;
    cyc(); push(1, "trigger", 1, 2, 0, 1, 1, 1);
    cyc(); push(1, "ring1", 1, 2, 1, 1, 1, 1);
    cyc(); push(1, "ring2", 1, 2, 2, 1, 1, 1);
    cyc(); push(1, "auto_off", 1, 2, 3, 1, 0, 0);

    // Snooze, held snooze ignored while snoozed, re-ring, stop
    load = 1'b1;
    cyc(); push(1, "reload", 1, 1, 3, 0, 0, 0);
    load = 1'b0;
    cyc(); push(1, "retrig", 1, 2, 0, 1, 1, 1);
    snooze = 1'b1;
    cyc(); push(1, "snooze", 1, 2, 1, 1, 0, 2);
    cyc(); push(1, "snz_ign", 1, 2, 2, 1, 0, 2);
    snooze = 1'b0;
    cyc(); push(1, "snz2", 1, 2, 3, 1, 0, 2);
    cyc(); push(1, "snz3", 1, 3, 0, 1, 0, 2);
    cyc(); push(1, "rering", 1, 3, 1, 1, 1, 1);
    stop = 1'b1;
    cyc(); push(1, "stop", 1, 3, 2, 1, 0, 0);
    stop = 1'b0;

    // Snooze and stop together
    load = 1'b1;
    cyc(); push(1, "reload2", 1, 1, 3, 0, 0, 0);
    load = 1'b0;
    cyc(); push(1, "ring_b", 1, 2, 0, 1, 1, 1);
    snooze = 1'b1; stop = 1'b1;
    cyc(); push(1, "snz_stop", 1, 2, 1, 1, 0, 0);
    snooze = 1'b0; stop = 1'b0;

    // ena low while ringing freezes time and ring counter
    load = 1'b1;
    cyc(); push(1, "reload3", 1, 1, 3, 0, 0, 0);
    load = 1'b0;
    cyc(); push(1, "ring_c", 1, 2, 0, 1, 1, 1);
    ena = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc(); push(1, "frozen", 1, 2, 0, 0, 1, 1);
    end
    ena = 1'b1;
    cyc(); push(1, "resume1", 1, 2, 1, 1, 1, 1);
    cyc(); push(1, "resume2", 1, 2, 2, 1, 1, 1);
    cyc(); push(1, "auto_off2", 1, 2, 3, 1, 0, 0);

    // Reset during snooze, then load at the (reverted) alarm time
    load = 1'b1;
    cyc(); push(1, "reload4", 1, 1, 3, 0, 0, 0);
    load = 1'b0;
    cyc(); push(1, "ring_d", 1, 2, 0, 1, 1, 1);
    snooze = 1'b1;
    cyc(); push(1, "snz_d", 1, 2, 1, 1, 0, 2);
    snooze = 1'b0; reset = 1'b0;
    cyc(); push(1, "reset_snz", 0, 0, 0, 0, 0, 0);
    reset = 1'b1; load = 1'b1; ld_h = 2'd0; ld_m = 3'd0; ld_s = 2'd0;
    cyc(); push(1, "load_at_alarm", 0, 0, 0, 0, 0, 0);
    load = 1'b0;
    cyc(); push(1, "no_trig", 0, 0, 1, 1, 0, 0);

    // Wrap into 0:0:0 triggers the reverted alarm; disarm forces idle
    load = 1'b1; ld_h = 2'd3; ld_m = 3'd7; ld_s = 2'd3;
    cyc(); push(1, "pre_wrap", 3, 7, 3, 0, 0, 0);
    load = 1'b0;
    cyc(); push(1, "wrap_trig", 0, 0, 0, 1, 1, 1);
    alarm_enable = 1'b0;
    cyc(); push(1, "disarm", 0, 0, 1, 1, 0, 0);

    @(negedge clk);
    #1;
    n_vec++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d records left unchecked, want 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
